if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder.
- Owns the PC and drives a request/ready instruction-memory port that may take a variable number of cycles per fetch.
- Delivers {instruction, PC+4, valid} to ID; the decoder consumes idInst.
- Honours hazard-unit stalls and branch/jump redirects from later stages; a flush inserts a NOP bubble.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word driven on idInst for a bubble (sll $0,$0,0)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
imemReq  out  1  fetch request to instruction memory
imemAddr  out  32  fetch address; always {pc[31:2],2'b00}
imemRdata  in  32  instruction word; valid only in a cycle with imemReq && imemReady
imemReady  in  1  memory completes the current request this cycle
stall  in  1  hazard unit: hold IF/ID and PC
redirect  in  1  taken branch/jump from a later stage: flush and refetch
redirectPC  in  32  new fetch address; bits [1:0] ignored (treated as 0)
idInst  out  32  IF/ID instruction to decoder
idPC4  out  32  IF/ID PC+4 of idInst
idValid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: pc=RESET_PC, state=FETCH, buffer empty, idInst=NOP_INST, idPC4=0, idValid=0. imemReq is 0 during the reset cycle and 1 in the first cycle after rst falls.
- States: FETCH (request outstanding), HOLD (word captured in internal buffer, waiting for the stall to clear).
- Priority each edge: rst > redirect > response/stall logic.
- FETCH: imemReq=1, imemAddr=pc. The memory treats req/addr as a level; a changed address restarts the access.
- FETCH, ready=1, stall=0: IF/ID <= {imemRdata, pc+4, 1}; pc <= pc+4; stay in FETCH. Back-to-back single-cycle fetches give one instruction per cycle.
- FETCH, ready=1, stall=1: buffer <= {imemRdata, pc+4}; IF/ID unchanged; go to HOLD. The PC is not advanced yet.
- FETCH, ready=0, stall=0: IF/ID <= bubble (NOP_INST, idPC4 unchanged, idValid=0).
- FETCH, ready=0, stall=1: IF/ID unchanged.
- HOLD: imemReq=0; imemReady is ignored.
  - stall=1: everything is held.
  - stall=0: IF/ID <= buffer with idValid=1; pc <= pc+4; go to FETCH. The next request issues in the following cycle.
- redirect=1 (any state, regardless of stall or ready):
  - pc <= {redirectPC[31:2],2'b00}; IF/ID <= bubble; buffer discarded; go to FETCH.
  - A word returned in the same cycle is dropped.
  - The new address appears on imemAddr the next cycle.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- idPC4 always equals the fetch address of idInst + 4 when idValid=1.
- No combinational path from stall/redirect to imemAddr; imemReq depends only on state and rst.

Test Plan:
- Reset then ready tied 1, mem[addr]=addr^32'hA5A5_0000 -> first req at 0x0; idInst sequence 0xA5A5_0000, 0xA5A5_0004, … one per cycle; idPC4 = 4, 8, …; idValid=1 continuously.
- Ready asserted every 3rd cycle, no stall -> two bubble cycles (idValid=0, idInst=0) between valid words; PC advances by 4 only on ready cycles.
- Stall held 4 cycles, asserted in a cycle where ready=1 at pc=0x10 -> IF/ID frozen on the prior instruction; imemReq=0 for cycles 2–4 (HOLD). On stall release, idInst=mem[0x10], idPC4=0x14, and the next request is at 0x14.
- Redirect to 0x0000_0103 in the same cycle as ready=1 at pc=0x20 -> returned word dropped; next cycle idValid=0 and imemAddr=0x100; later idPC4=0x104.
- Redirect while in HOLD with stall=1 -> buffer discarded, idValid=0 next cycle, state FETCH at the target; stall does not block the flush.
- rst asserted mid-fetch (ready=0, pc=0x40) -> next cycle pc=RESET_PC, idValid=0, imemReq=0; then fetching resumes from RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a level-sensitive request/ready instruction-memory
// port, and hands {instruction, PC+4, valid} to the decoder. A one-entry
// hold buffer parks a word that returns while the hazard unit is stalling,
// so the memory access never has to be repeated.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemReady,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic [31:0] idInst,
    output logic [31:0] idPC4,
    output logic        idValid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_p0;
    logic [31:0] pc_p0;
    logic [31:0] hold_inst_p0;
    logic [31:0] hold_pc4_p0;
    logic [31:0] inst_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;
    logic [31:0] redirect_tgt;
    logic        capture_hold;

    // Sequential PC step; plain 32-bit modulo wrap at the top of memory.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Request is a pure function of state and reset: no path from stall/redirect.
    assign imemReq  = (state_p0 == FETCH) && !rst;
    assign imemAddr = pc_p0 & 32'hFFFF_FFFC;

    // Redirect targets are forced word aligned.
    assign redirect_tgt = redirectPC & 32'hFFFF_FFFC;

    // A word arriving while stalled is parked instead of written to IF/ID.
    assign capture_hold = !rst && !redirect && (state_p0 == FETCH) && imemReady && stall;

    // ---- stage p0: hold buffer (data only, qualified by HOLD state) ----
    // Park the returned word and its PC+4 until the stall clears.
    always_ff @(posedge clk) begin
        if (capture_hold) begin
            hold_inst_p0 <= imemRdata;
            hold_pc4_p0  <= pc_step(pc_p0);
        end
    end

    // ---- stage p0 -> p1: PC, FSM and IF/ID register ----
    // Advance the PC and load IF/ID; reset beats redirect beats response/stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0    <= RESET_PC;
            state_p0 <= FETCH;
            inst_p1  <= NOP_INST;
            pc4_p1   <= 32'h0000_0000;
            vld_p1   <= 1'b0;
        end else if (redirect) begin
            // Flush: any word returned this cycle and any parked word are dropped.
            pc_p0    <= redirect_tgt;
            state_p0 <= FETCH;
            inst_p1  <= NOP_INST;
            vld_p1   <= 1'b0;
        end else begin
            case (state_p0)
                FETCH: begin
                    if (imemReady) begin
                        if (!stall) begin
                            inst_p1 <= imemRdata;
                            pc4_p1  <= pc_step(pc_p0);
                            vld_p1  <= 1'b1;
                            pc_p0   <= pc_step(pc_p0);
                        end else begin
                            // PC advances only when the parked word is released.
                            state_p0 <= HOLD;
                        end
                    end else if (!stall) begin
                        // Memory still busy: hand a bubble to decode, keep idPC4.
                        inst_p1 <= NOP_INST;
                        vld_p1  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_p1  <= hold_inst_p0;
                        pc4_p1   <= hold_pc4_p0;
                        vld_p1   <= 1'b1;
                        pc_p0    <= pc_step(pc_p0);
                        state_p0 <= FETCH;
                    end
                end
                default: state_p0 <= FETCH;
            endcase
        end
    end

    assign idInst  = inst_p1;
    assign idPC4   = pc4_p1;
    assign idValid = vld_p1;

endmodule
